// File: rtl/servo_frame_sched.sv
// Table-driven servo frame sequencer: formats keyframe entries as ASCII commands onto a byte stream.
// Build option: define SERVO_SCHED_LOOP_EN to repeat the schedule until abort/reset.
module servo_frame_sched #(
  parameter int CLK_FREQ = 50000000,
  parameter int SERVOS   = 5,
  parameter int FRAME_W  = 8,
  parameter int ADDR_W   = 11,
  parameter int PWM_MIN  = 500,
  parameter int PWM_MAX  = 2500
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [FRAME_W-1:0] num_frames,
  output logic [ADDR_W-1:0]  tbl_addr,
  input  logic [31:0]        tbl_rdata,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               done
);

  localparam int TICK   = (CLK_FREQ >= 2000) ? CLK_FREQ / 1000 : 1;
  localparam int TICK_W = (TICK > 1) ? $clog2(TICK) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FETCH, S_CONV, S_EMIT, S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;
  logic [FRAME_W-1:0] frame_q, frame_d, frame_nx;
  logic [FRAME_W-1:0] nframes_q, nframes_d;
  logic [15:0]        fbcd_q, fbcd_d;
  logic [3:0]         servo_q, servo_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [27:0]        id_cv_q, id_cv_d;
  logic [27:0]        pwm_cv_q, pwm_cv_d;
  logic [27:0]        t_cv_q, t_cv_d;
  logic [11:0]        maxt_q, maxt_d;
  logic [11:0]        ms_q, ms_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [11:0]        pwm_c;
  logic               can_load;
  logic [7:0]         cur_byte;

  // One double-dabble iteration on {bcd[15:0], bin[11:0]}
  function automatic logic [27:0] dd_step(input logic [27:0] v);
    logic [27:0] r;
    r = v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r[12+4*i +: 4] >= 4'd5) r[12+4*i +: 4] = r[12+4*i +: 4] + 4'd3;
    end
    return {r[26:0], 1'b0};
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] asc(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign done      = done_q;
  assign frame_idx = frame_q;
  assign busy      = (state_q != S_IDLE);
  assign tbl_addr  = ADDR_W'(frame_q) * ADDR_W'(SERVOS) + ADDR_W'(servo_q);

  always_comb begin
    cur_byte = 8'h00;
    if (state_q == S_HDR) begin
      case (cnt_q)
        4'd0:    cur_byte = 8'h47;
        4'd1:    cur_byte = asc(fbcd_q[15:12]);
        4'd2:    cur_byte = asc(fbcd_q[11:8]);
        4'd3:    cur_byte = asc(fbcd_q[7:4]);
        default: cur_byte = asc(fbcd_q[3:0]);
      endcase
    end else begin
      case (cnt_q)
        4'd0:    cur_byte = 8'h23;
        4'd1:    cur_byte = asc(id_cv_q[23:20]);
        4'd2:    cur_byte = asc(id_cv_q[19:16]);
        4'd3:    cur_byte = asc(id_cv_q[15:12]);
        4'd4:    cur_byte = 8'h50;
        4'd5:    cur_byte = asc(pwm_cv_q[27:24]);
        4'd6:    cur_byte = asc(pwm_cv_q[23:20]);
        4'd7:    cur_byte = asc(pwm_cv_q[19:16]);
        4'd8:    cur_byte = asc(pwm_cv_q[15:12]);
        4'd9:    cur_byte = 8'h54;
        4'd10:   cur_byte = asc(t_cv_q[27:24]);
        4'd11:   cur_byte = asc(t_cv_q[23:20]);
        4'd12:   cur_byte = asc(t_cv_q[19:16]);
        4'd13:   cur_byte = asc(t_cv_q[15:12]);
        default: cur_byte = 8'h21;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    done_d     = 1'b0;
    abort_d    = abort_q;
    frame_d    = frame_q;
    nframes_d  = nframes_q;
    fbcd_d     = fbcd_q;
    servo_d    = servo_q;
    cnt_d      = cnt_q;
    id_cv_d    = id_cv_q;
    pwm_cv_d   = pwm_cv_q;
    t_cv_d     = t_cv_q;
    maxt_d     = maxt_q;
    ms_d       = ms_q;
    tick_d     = tick_q;
    frame_nx   = frame_q + 1'b1;
    can_load   = !tx_valid_q || tx_ready;
    pwm_c      = tbl_rdata[23:12];
    if (pwm_c < 12'(PWM_MIN)) pwm_c = 12'(PWM_MIN);
    if (pwm_c > 12'(PWM_MAX)) pwm_c = 12'(PWM_MAX);

    if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;

    // Abort waits for a presented byte to be taken so the link never sees a retracted byte
    if (state_q != S_IDLE && (abort || abort_q)) begin
      if (tx_valid_q && !tx_ready) abort_d = 1'b1;
      else begin
        state_d = S_IDLE;
        abort_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          abort_d = 1'b0;
          if (start && !abort) begin
            if (num_frames == '0) done_d = 1'b1;
            else begin
              state_d   = S_HDR;
              nframes_d = num_frames;
              frame_d   = '0;
              fbcd_d    = '0;
              servo_d   = '0;
              cnt_d     = '0;
            end
          end
        end
        S_HDR: begin
          if (can_load) begin
            if (cnt_q != 4'd5) begin
              tx_valid_d = 1'b1;
              tx_data_d  = cur_byte;
              cnt_d      = cnt_q + 4'd1;
            end else begin
              cnt_d   = '0;
              servo_d = '0;
              state_d = S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (cnt_q == 4'd0) cnt_d = 4'd1;
          else begin
            cnt_d    = '0;
            id_cv_d  = {16'h0000, 4'h0, tbl_rdata[31:24]};
            pwm_cv_d = {16'h0000, pwm_c};
            t_cv_d   = {16'h0000, tbl_rdata[11:0]};
            if (servo_q == 4'd0 || tbl_rdata[11:0] > maxt_q) maxt_d = tbl_rdata[11:0];
            state_d  = S_CONV;
          end
        end
        S_CONV: begin
          id_cv_d  = dd_step(id_cv_q);
          pwm_cv_d = dd_step(pwm_cv_q);
          t_cv_d   = dd_step(t_cv_q);
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == 4'd11) begin
            cnt_d   = '0;
            state_d = S_EMIT;
          end
        end
        S_EMIT: begin
          if (can_load) begin
            if (cnt_q != 4'd15) begin
              tx_valid_d = 1'b1;
              tx_data_d  = cur_byte;
              cnt_d      = cnt_q + 4'd1;
            end else begin
              cnt_d = '0;
              if (servo_q == 4'(SERVOS - 1)) begin
                state_d = S_GAP;
                ms_d    = '0;
                tick_d  = '0;
              end else begin
                servo_d = servo_q + 4'd1;
                state_d = S_FETCH;
              end
            end
          end
        end
        S_GAP: begin
          if (maxt_q == '0 || (ms_q == maxt_q - 12'd1 && tick_q == TICK_W'(TICK - 1))) begin
            servo_d = '0;
            cnt_d   = '0;
            if (frame_q == nframes_q - 1'b1) begin
              done_d = 1'b1;
`ifdef SERVO_SCHED_LOOP_EN
              frame_d = '0;
              fbcd_d  = '0;
              state_d = S_HDR;
`else
              state_d = S_IDLE;
`endif
            end else begin
              frame_d = frame_nx;
              fbcd_d  = (frame_nx == '0) ? 16'h0000 : bcd_inc(fbcd_q);
              state_d = S_HDR;
            end
          end else if (tick_q == TICK_W'(TICK - 1)) begin
            tick_d = '0;
            ms_d   = ms_q + 12'd1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      frame_q    <= '0;
      nframes_q  <= '0;
      fbcd_q     <= '0;
      servo_q    <= '0;
      cnt_q      <= '0;
      id_cv_q    <= '0;
      pwm_cv_q   <= '0;
      t_cv_q     <= '0;
      maxt_q     <= '0;
      ms_q       <= '0;
      tick_q     <= '0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      frame_q    <= frame_d;
      nframes_q  <= nframes_d;
      fbcd_q     <= fbcd_d;
      servo_q    <= servo_d;
      cnt_q      <= cnt_d;
      id_cv_q    <= id_cv_d;
      pwm_cv_q   <= pwm_cv_d;
      t_cv_q     <= t_cv_d;
      maxt_q     <= maxt_d;
      ms_q       <= ms_d;
      tick_q     <= tick_d;
    end
  end

endmodule

// File: tb/tb_servo_frame_sched.sv
// Directed/randomized bench for servo_frame_sched against an ASCII-stream reference model.
module tb_servo_frame_sched;
  localparam int SERVOS  = 5;
  localparam int FRAME_W = 8;
  localparam int ADDR_W  = 11;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [FRAME_W-1:0] num_frames = '0;
  logic [ADDR_W-1:0]  tbl_addr;
  logic [31:0]        tbl_rdata = '0;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready = 1'b0;
  logic               busy;
  logic [FRAME_W-1:0] frame_idx;
  logic               done;

  servo_frame_sched #(.CLK_FREQ(1000), .SERVOS(SERVOS), .FRAME_W(FRAME_W), .ADDR_W(ADDR_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
    .num_frames(num_frames), .tbl_addr(tbl_addr), .tbl_rdata(tbl_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_idx(frame_idx), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  int  done_cnt = 0, done_cyc = 0, last_acc = 0, stall_err = 0;
  bit  busy_seen = 0, valid_seen = 0, prev_stall = 0;
  logic [7:0] prev_data = '0;
  bit   rdy_mode = 0;
  logic rdy_val = 1'b1;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(posedge sys_clk) tbl_rdata <= mem[tbl_addr];

  initial forever begin
    @(posedge sys_clk);
    #1;
    tx_ready = rdy_mode ? ($urandom_range(0, 1) == 1) : rdy_val;
  end

  always @(negedge sys_clk) begin
    if (sys_rst) prev_stall = 0;
    else begin
      if (prev_stall && !(tx_valid && tx_data == prev_data)) stall_err++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        last_acc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_seen = 1;
      if (tx_valid) valid_seen = 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #3;
    end
  endtask

  task automatic push_dec(input int unsigned v, input int unsigned nd);
    int unsigned div;
    div = 1;
    for (int unsigned i = 1; i < nd; i++) div *= 10;
    for (int unsigned i = 0; i < nd; i++) begin
      exp_q.push_back(8'(32'h30 + (v / div) % 10));
      div /= 10;
    end
  endtask

  task automatic build_exp(input int nf);
    logic [31:0] e;
    int unsigned pwm;
    exp_q.delete();
    for (int f = 0; f < nf; f++) begin
      exp_q.push_back(8'h47);
      push_dec(f % 10000, 4);
      for (int s = 0; s < SERVOS; s++) begin
        e = mem[f * SERVOS + s];
        pwm = e[23:12];
        if (pwm < 500) pwm = 500;
        if (pwm > 2500) pwm = 2500;
        exp_q.push_back(8'h23); push_dec(e[31:24], 3);
        exp_q.push_back(8'h50); push_dec(pwm, 4);
        exp_q.push_back(8'h54); push_dec(e[11:0], 4);
        exp_q.push_back(8'h21);
      end
    end
  endtask

  task automatic compare_stream(input string tag, input int nf);
    build_exp(nf);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) check($sformatf("%s_b%0d", tag, i), got[i], exp_q[i]);
    end
  endtask

  task automatic rand_table(input int nf, input int tmax);
    int id, pwm, t;
    for (int a = 0; a < nf * SERVOS; a++) begin
      id  = $urandom_range(0, 255);
      pwm = $urandom_range(0, 4095);
      t   = $urandom_range(0, tmax);
      mem[a] = {id[7:0], pwm[11:0], t[11:0]};
    end
  endtask

  task automatic pulse_start(input int nf);
    num_frames = FRAME_W'(nf);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int maxc);
    for (int i = 0; i < maxc && done_cnt == d0; i++) tick(1);
    check({tag, "_done"}, done_cnt - d0, 1);
    tick(2);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic run_sched(input string tag, input int nf, input int maxc);
    int d0;
    got.delete();
    d0 = done_cnt;
    pulse_start(nf);
    wait_done(tag, d0, maxc);
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int i;
    for (i = 0; i < 2000 && got.size() < n; i++) tick(1);
    if (i == 2000) check({tag, "_timeout"}, got.size(), n);
  endtask

  initial begin
    int d0, held, gap;
    logic [7:0] h;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = '0;

    tick(3);
    check("rst_valid", tx_valid, 1'b0);
    check("rst_data", tx_data, 8'h00);
    check("rst_addr", tbl_addr, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_fidx", frame_idx, 0);
    check("rst_done", done, 1'b0);
    sys_rst = 1'b0;
    tick(2);

    mem[0] = {8'd0, 12'd1500, 12'd1000};
    for (int s = 1; s < SERVOS; s++) mem[s] = {8'(s), 12'd1500, 12'd0};
    run_sched("t1", 1, 3000);
    compare_stream("t1", 1);
    gap = done_cyc - last_acc;
    check("t1_gap", (gap >= 999 && gap <= 1003), 1'b1);

    mem[0] = {8'd7,   12'd300,  12'd1};
    mem[1] = {8'd255, 12'd3000, 12'd2};
    mem[2] = {8'd42,  12'd499,  12'd0};
    mem[3] = {8'd99,  12'd2501, 12'd9};
    mem[4] = {8'd100, 12'd4095, 12'd3};
    run_sched("clamp", 1, 200);
    compare_stream("clamp", 1);

    rand_table(3, 0);
    run_sched("nf3", 3, 1000);
    compare_stream("nf3", 3);

    rand_table(2, 5);
    got.delete();
    stall_err = 0;
    rdy_mode = 1;
    d0 = done_cnt;
    pulse_start(2);
    tick(40);
    pulse_start(7);
    wait_done("rrdy", d0, 5000);
    rdy_mode = 0;
    compare_stream("rrdy", 2);
    check("rrdy_stall", stall_err, 0);

    busy_seen = 0;
    valid_seen = 0;
    run_sched("nf0", 0, 20);
    check("nf0_busy", busy_seen, 1'b0);
    check("nf0_valid", valid_seen, 1'b0);
    check("nf0_bytes", got.size(), 0);

    rand_table(2, 3);
    got.delete();
    stall_err = 0;
    rdy_val = 1'b1;
    d0 = done_cnt;
    pulse_start(2);
    wait_bytes("abort", 7);
    rdy_val = 1'b0;
    tick(2);
    h = tx_data;
    held = got.size();
    check("abort_hold_valid", tx_valid, 1'b1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(4);
    check("abort_still_valid", tx_valid, 1'b1);
    check("abort_still_data", tx_data, h);
    check("abort_still_busy", busy, 1'b1);
    rdy_val = 1'b1;
    tick(8);
    check("abort_busy", busy, 1'b0);
    check("abort_valid", tx_valid, 1'b0);
    check("abort_count", got.size(), held + 1);
    if (got.size() > held) check("abort_byte", got[held], h);
    build_exp(2);
    check("abort_model", h, exp_q[held]);
    check("abort_nodone", done_cnt, d0);
    check("abort_stall", stall_err, 0);

    rand_table(1, 2);
    got.delete();
    pulse_start(1);
    wait_bytes("mrst", 3);
    rdy_val = 1'b0;
    tick(2);
    check("mrst_pending", tx_valid, 1'b1);
    sys_rst = 1'b1;
    tick(1);
    check("mrst_valid", tx_valid, 1'b0);
    check("mrst_data", tx_data, 8'h00);
    check("mrst_busy", busy, 1'b0);
    check("mrst_fidx", frame_idx, 0);
    sys_rst = 1'b0;
    rdy_val = 1'b1;
    tick(3);
    check("mrst_quiet", tx_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/servo_frame_sched.md
Name: servo_frame_sched

Overview:
Sequencer that drives servo-group command frames out through a byte-wide UART transmitter. It walks a keyframe table, formats each frame as ASCII text, and streams the bytes over a valid/ready handshake. Between frames it waits for the longest move time in the frame. It sits between the table storage and the UART TX byte engine, and replaces hard-coded command strings with a table-driven schedule.

Parameters:
CLK_FREQ, 50000000, sys_clk frequency in Hz; one ms tick = CLK_FREQ/1000 cycles
SERVOS, 5, servo entries per frame (1..15)
FRAME_W, 8, width of frame count/index
ADDR_W, 11, table address width; must hold FRAME_W-bit frame index * SERVOS
PWM_MIN, 500, PWM clamp low (µs)
PWM_MAX, 2500, PWM clamp high (µs)

Ports:
sys_clk  in  1  clock
sys_rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; begins schedule from frame 0 when idle
abort  in  1  stop schedule (see Behaviour)
num_frames  in  FRAME_W  frames to send; sampled on accepted start
tbl_addr  out  ADDR_W  table read address = frame*SERVOS + servo
tbl_rdata  in  32  entry read data, valid 1 cycle after tbl_addr; [31:24] ID, [23:12] PWM, [11:0] T (ms)
tx_data  out  8  byte to UART TX
tx_valid  out  1  byte valid
tx_ready  in  1  TX accepts byte when tx_valid&tx_ready
busy  out  1  high from accepted start until return to IDLE
frame_idx  out  FRAME_W  index of current frame
done  out  1  one-cycle pulse when the schedule completes normally

Behaviour:
- Reset values: tx_valid=0, tx_data=0, tbl_addr=0, busy=0, frame_idx=0, done=0. State=IDLE. Timers/counters=0. Reset mid-frame drops any pending byte immediately.
- Frame byte stream: "G" + 4 decimal digits of frame_idx (MSD first), then per servo s=0..SERVOS-1: "#" + 3-digit ID + "P" + 4-digit PWM + "T" + 4-digit T + "!". Bytes per frame = 5 + 15*SERVOS (80 at default). Digits are ASCII 0x30+d with leading zeros.
- PWM is clamped to [PWM_MIN,PWM_MAX] before formatting. T>9999 cannot occur (12 bits). ID 0..255.
- States:
  - IDLE: start with num_frames!=0 -> HDR, busy=1, frame_idx=0. start with num_frames==0 -> done pulse next cycle, stays IDLE, busy stays 0. start while busy is ignored.
  - HDR: emit the 5 header bytes.
  - FETCH: drive tbl_addr, capture tbl_rdata 1 cycle later.
  - CONV: binary->BCD, sequential; at most 16 cycles per entry.
  - EMIT: emit 15 bytes; then next servo -> FETCH, or after the last servo -> GAP.
  - GAP: wait maxT ms, where maxT = max of T over the frame (computed during fetch). maxT=0 -> no wait, exit after 1 cycle. Then frame_idx+1 -> HDR, or after the last frame -> IDLE with done=1 for 1 cycle.
- Handshake: tx_data is stable while tx_valid=1. tx_valid never drops until tx_ready is seen. Next byte may be presented the cycle after acceptance (1 byte/cycle max throughput). No bytes are emitted outside HDR/EMIT.
- Abort:
  - If tx_valid=1 and not accepted, hold tx_valid until accepted, then go IDLE.
  - Otherwise go IDLE next cycle.
  - done is not pulsed. busy drops on entry to IDLE. Abort in IDLE has no effect.
  - abort and start in the same cycle in IDLE: abort wins and start is ignored.
- ms timer: counts CLK_FREQ/1000 cycles per ms. It runs only in GAP and clears on GAP entry.
- frame_idx wraps modulo 2^FRAME_W. Header digits show frame_idx mod 10000.

Optional Feature:
SERVO_SCHED_LOOP_EN
- Defined: after GAP of the last frame, frame_idx returns to 0 and the block continues at HDR indefinitely. done pulses once per completed pass. Only abort or reset stops it.
- Undefined: the block stops in IDLE after the last frame, as above.

Test Plan:
- CLK_FREQ=1000, SERVOS=5, num_frames=1, entry0={ID 0, PWM 1500, T 1000}, others={ID s, PWM 1500, T 0}, tx_ready=1 -> exactly 80 bytes "G0000#000P1500T1000!#001P1500T0000!..." then 1000 cycles of GAP, then done pulse and busy=0.
- PWM 300 and PWM 3000 entries -> formatted as "P0500" and "P2500".
- tx_ready toggling randomly -> tx_data/tx_valid stable while stalled. Byte sequence is identical to the tx_ready=1 run and no byte is lost or duplicated.
- abort asserted while tx_valid=1, tx_ready=0 for 5 cycles -> byte held, accepted on ready, then IDLE. No done, no further bytes.
- num_frames=0 with start -> done pulse, busy stays 0, no tx_valid. start during busy -> ignored, stream unchanged.
- num_frames=3, all T=0 -> headers G0000/G0001/G0002 back-to-back, single done. With SERVO_SCHED_LOOP_EN: the sequence repeats G0000 after G0002 with done on each pass.
